// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared types and defaults for the multi-read-port register file
package reg_file_mp_pkg;

   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;
   localparam int NRD_DEF  = 2;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   // Per-port source of the visible read data, captured alongside the bank read
   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_MEM  = 2'd1,
      SEL_BYP  = 2'd2
   } rd_sel_t;

endpackage

// File: rtl/reg_file_mp_bank.sv
// rtl/reg_file_mp_bank.sv - one write port, one registered read-first read port
module rf_read_bank #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            re,
   input  logic [AW-1:0]   raddr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [2**AW];

   // Read sees the pre-write contents on a same-edge collision
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - NRD-read/1-write register file with clear FSM; REGFILE_BYPASS_EN selects write-first collisions
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = AW_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              reg_enabl,
   input  logic              wr_enabl,
   input  logic [AW-1:0]     dst_addr,
   input  logic [XLEN-1:0]   dst_data,
   input  logic [NRD*AW-1:0] src_addr,
   output logic [NRD*XLEN-1:0] src_data,
   output logic              init_done
);

   localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   rf_state_t       state_q, state_d;
   logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
   logic            init_done_q;

   logic            in_run;
   logic            rd_cap;
   logic            dst_is_x0;
   logic            wr_act;
   logic            bank_we;
   logic [AW-1:0]   bank_waddr;
   logic [XLEN-1:0] bank_wdata;

   logic [XLEN-1:0] bank_rd [NRD];
   rd_sel_t         sel_d [NRD];
   rd_sel_t         sel_q [NRD];

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q     <= RF_CLEAR;
         clr_ptr_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         init_done_q <= (state_d == RF_RUN);
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         RF_CLEAR: begin
            clr_ptr_d = clr_ptr_q + PTR_ONE;
            if (clr_ptr_q == LAST_PTR) begin
               state_d = RF_RUN;
            end
         end
         RF_RUN: begin
            state_d = RF_RUN;
         end
         default: begin
            state_d = RF_CLEAR;
         end
      endcase
   end

   assign init_done = init_done_q;

   assign in_run    = (state_q == RF_RUN);
   assign rd_cap    = in_run & reg_enabl;
   assign dst_is_x0 = (ZERO_REG != 0) && (dst_addr == '0);
   assign wr_act    = rd_cap & wr_enabl & ~dst_is_x0;

   // While clearing, every bank is driven by the clear pointer and zero data
   assign bank_we    = ~in_run | wr_act;
   assign bank_waddr = in_run ? dst_addr : clr_ptr_q;
   assign bank_wdata = in_run ? dst_data : '0;

   generate
      for (genvar p = 0; p < NRD; p++) begin : g_port
         rf_read_bank #(
            .XLEN (XLEN),
            .AW   (AW)
         ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (rd_cap),
            .raddr (src_addr[p*AW +: AW]),
            .rdata (bank_rd[p])
         );
      end
   endgenerate

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         sel_d[p] = SEL_MEM;
         if ((ZERO_REG != 0) && (src_addr[p*AW +: AW] == '0)) begin
            sel_d[p] = SEL_ZERO;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_act && (dst_addr == src_addr[p*AW +: AW])) begin
            sel_d[p] = SEL_BYP;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NRD; p++) begin
         if (!resetb || !in_run) begin
            sel_q[p] <= SEL_ZERO;
         end else if (rd_cap) begin
            sel_q[p] <= sel_d[p];
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   // All ports capture together, so one forwarded-data register serves every port
   logic [XLEN-1:0] byp_q;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         byp_q <= '0;
      end else if (rd_cap) begin
         byp_q <= dst_data;
      end
   end

   always_comb begin
      src_data = '0;
      for (int p = 0; p < NRD; p++) begin
         case (sel_q[p])
            SEL_MEM: src_data[p*XLEN +: XLEN] = bank_rd[p];
            SEL_BYP: src_data[p*XLEN +: XLEN] = byp_q;
            default: src_data[p*XLEN +: XLEN] = '0;
         endcase
      end
   end
`else
   always_comb begin
      src_data = '0;
      for (int p = 0; p < NRD; p++) begin
         if (sel_q[p] == SEL_MEM) begin
            src_data[p*XLEN +: XLEN] = bank_rd[p];
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (default config and NRD=4/AW=4/ZERO_REG=0)
module tb_reg_file_mp;

   typedef struct {
      int           due;
      bit           dut;
      logic [127:0] exp;
      logic [3:0]   mask;
      logic         exp_init;
      string        name;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   logic         resetb_a, reg_enabl_a, wr_enabl_a;
   logic [4:0]   dst_addr_a;
   logic [31:0]  dst_data_a;
   logic [9:0]   src_addr_a;
   logic [63:0]  src_data_a;
   logic         init_done_a;

   logic         resetb_b, reg_enabl_b, wr_enabl_b;
   logic [3:0]   dst_addr_b;
   logic [31:0]  dst_data_b;
   logic [15:0]  src_addr_b;
   logic [127:0] src_data_b;
   logic         init_done_b;

   reg_file_mp u_dut_a (
      .clk       (clk),
      .resetb    (resetb_a),
      .reg_enabl (reg_enabl_a),
      .wr_enabl  (wr_enabl_a),
      .dst_addr  (dst_addr_a),
      .dst_data  (dst_data_a),
      .src_addr  (src_addr_a),
      .src_data  (src_data_a),
      .init_done (init_done_a)
   );

   reg_file_mp #(.XLEN(32), .AW(4), .NRD(4), .ZERO_REG(0)) u_dut_b (
      .clk       (clk),
      .resetb    (resetb_b),
      .reg_enabl (reg_enabl_b),
      .wr_enabl  (wr_enabl_b),
      .dst_addr  (dst_addr_b),
      .dst_data  (dst_data_b),
      .src_addr  (src_addr_b),
      .src_data  (src_data_b),
      .init_done (init_done_b)
   );

   exp_t         mon_e;
   logic [127:0] mon_act;
   logic         mon_init;

   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.dut == 1'b0) begin
            mon_act  = {64'h0, src_data_a};
            mon_init = init_done_a;
         end else begin
            mon_act  = src_data_b;
            mon_init = init_done_b;
         end
         checks++;
         if (mon_init !== mon_e.exp_init) begin
            errors++;
            $display("FAIL %s init_done got %0b want %0b (cycle %0d)", mon_e.name, mon_init, mon_e.exp_init, cyc);
         end
         for (int p = 0; p < 4; p++) begin
            if (mon_e.mask[p]) begin
               checks++;
               if (mon_act[p*32 +: 32] !== mon_e.exp[p*32 +: 32]) begin
                  errors++;
                  $display("FAIL %s port%0d got %h want %h (cycle %0d)", mon_e.name, p, mon_act[p*32 +: 32], mon_e.exp[p*32 +: 32], cyc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit dut, input int due, input logic [127:0] exp, input logic [3:0] mask,
                       input logic init, input string name);
      exp_t e;
      e.due = due; e.dut = dut; e.exp = exp; e.mask = mask; e.exp_init = init; e.name = name;
      sb.push_back(e);
   endtask

   task automatic set_a(input logic re, input logic we, input logic [4:0] dst, input logic [31:0] data,
                        input logic [4:0] s0, input logic [4:0] s1);
      reg_enabl_a = re; wr_enabl_a = we; dst_addr_a = dst; dst_data_a = data; src_addr_a = {s1, s0};
   endtask

   task automatic set_b(input logic re, input logic we, input logic [3:0] dst, input logic [31:0] data,
                        input logic [3:0] s);
      reg_enabl_b = re; wr_enabl_b = we; dst_addr_b = dst; dst_data_b = data; src_addr_b = {4{s}};
   endtask

   logic [31:0] coll_exp;
   int k;

   initial begin
      resetb_a = 1'b0;
      resetb_b = 1'b0;
      set_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      set_b(1'b0, 1'b0, 4'd0, 32'h0, 4'd0);
      repeat (3) tick();
      push(0, cyc, 128'h0, 4'b0011, 1'b0, "a_reset");
      push(1, cyc, 128'h0, 4'b1111, 1'b0, "b_reset");

      // Release A with a write and reads attempted during CLEAR; both must be ignored
      resetb_a = 1'b1;
      set_a(1'b1, 1'b1, 5'd9, 32'h55, 5'd9, 5'd0);
      k = cyc;
      for (int i = 1; i <= 32; i++) push(0, k + i, 128'h0, 4'b0011, (i == 32), "a_clear");
      repeat (32) tick();

      set_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
      for (int a = 0; a < 32; a++) begin
         src_addr_a = {5'(31 - a), 5'(a)};
         push(0, cyc + 1, 128'h0, 4'b0011, 1'b1, "a_zero_sweep");
         tick();
      end

      set_a(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      push(0, cyc + 1, 128'h0, 4'b0011, 1'b1, "a_wr_r5");
      tick();
      set_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      push(0, cyc + 1, {64'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 4'b0011, 1'b1, "a_rd_r5");
      tick();

      set_a(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd5, 5'd5);
      push(0, cyc + 1, {64'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 4'b0011, 1'b1, "a_wr_r0");
      tick();
      set_a(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
      push(0, cyc + 1, 128'h0, 4'b0011, 1'b1, "a_x0_collide");
      tick();
      set_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      push(0, cyc + 1, 128'h0, 4'b0011, 1'b1, "a_rd_r0");
      tick();

`ifdef REGFILE_BYPASS_EN
      coll_exp = 32'h2;
`else
      coll_exp = 32'h1;
`endif
      set_a(1'b1, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
      push(0, cyc + 1, 128'h0, 4'b0011, 1'b1, "a_wr_r7_1");
      tick();
      set_a(1'b1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd5);
      push(0, cyc + 1, {64'h0, 32'hDEADBEEF, coll_exp}, 4'b0011, 1'b1, "a_collide_r7");
      tick();
      set_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      push(0, cyc + 1, {64'h0, 32'h2, 32'h2}, 4'b0011, 1'b1, "a_rd_r7");
      tick();

      set_a(1'b0, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd9);
      push(0, cyc + 1, {64'h0, 32'h2, 32'h2}, 4'b0011, 1'b1, "a_hold");
      tick();
      set_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
      push(0, cyc + 1, 128'h0, 4'b0011, 1'b1, "a_rd_r3_r9");
      tick();
      set_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Second instance: ordinary r0 and reset during re-initialisation
      resetb_b = 1'b1;
      k = cyc;
      for (int i = 1; i <= 16; i++) push(1, k + i, 128'h0, 4'b1111, (i == 16), "b_clear");
      repeat (16) tick();

      set_b(1'b1, 1'b1, 4'd0, 32'h12345678, 4'd2);
      push(1, cyc + 1, 128'h0, 4'b1111, 1'b1, "b_wr_r0");
      tick();
      set_b(1'b1, 1'b0, 4'd0, 32'h0, 4'd0);
      push(1, cyc + 1, {4{32'h12345678}}, 4'b1111, 1'b1, "b_rd_r0");
      tick();
      set_b(1'b1, 1'b1, 4'd1, 32'hAA, 4'd2);
      push(1, cyc + 1, 128'h0, 4'b1111, 1'b1, "b_wr_r1");
      tick();
      set_b(1'b1, 1'b0, 4'd0, 32'h0, 4'd1);
      push(1, cyc + 1, {4{32'hAA}}, 4'b1111, 1'b1, "b_rd_r1");
      tick();

      resetb_b = 1'b0;
      set_b(1'b0, 1'b0, 4'd0, 32'h0, 4'd1);
      tick();
      push(1, cyc, 128'h0, 4'b1111, 1'b0, "b_reset2");
      resetb_b = 1'b1;
      repeat (6) tick();
      resetb_b = 1'b0;
      tick();
      push(1, cyc, 128'h0, 4'b1111, 1'b0, "b_reset_midclear");
      resetb_b = 1'b1;
      set_b(1'b1, 1'b0, 4'd0, 32'h0, 4'd1);
      k = cyc;
      for (int i = 1; i <= 16; i++) push(1, k + i, 128'h0, 4'b1111, (i == 16), "b_reclear");
      repeat (16) tick();
      push(1, cyc + 1, 128'h0, 4'b1111, 1'b1, "b_rd_r1_after");
      tick();
      src_addr_b = {4'd15, 4'd6, 4'd1, 4'd0};
      push(1, cyc + 1, 128'h0, 4'b1111, 1'b1, "b_rd_mixed");
      tick();
      set_b(1'b0, 1'b0, 4'd0, 32'h0, 4'd0);

      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
